// File: rtl/dmem_delay_responder.sv
// dmem_delay_responder: word-addressed data memory answering one load/store
// at a time after LATENCY wait cycles, with a req/busy/ready handshake.
// Optional byte-enable stores are compiled in with `define DMEM_BYTE_EN.
module dmem_delay_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx_d;
  logic                  aligned_d;
  logic                  mem_we_d;
  logic [3:0]            byte_we_d;

  // Address bits above the memory window are deliberately dropped (wrap).
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  // Decode the latched request into word index and write strobes.
  always_comb begin
    idx_d     = addr_q[ADDR_WIDTH+1:2];
    aligned_d = (addr_q[1:0] == 2'b00);
    mem_we_d  = (state_q == S_RESP) && we_q && aligned_d;
    byte_we_d = be_q;
  end

  // Memory array: written only in RESP for an aligned store; never reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_we_d[b]) begin
          mem[idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Request FSM with registered busy/ready/err/rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      // Lagging the state by one cycle covers acceptance+1 through the ready cycle.
      busy_q  <= (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_WIDTH+1:0];
            wdata_q <= wdata;
`ifdef DMEM_BYTE_EN
            be_q    <= be;
`else
            be_q    <= '1;
`endif
            cnt_q   <= LAT_CNT;
            state_q <= (LATENCY > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          if (!aligned_d) begin
            err_q <= 1'b1;
          end else if (!we_q) begin
            rdata_q <= mem[idx_d];
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_delay_responder.sv
// Directed bench for dmem_delay_responder: one instance with LATENCY=2 and
// one with LATENCY=0, expected values computed by hand.
module tb_dmem_delay_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req2, we2, busy2, ready2, err2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        req0, we0, busy0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_BYTE_EN
  logic [3:0]  be2;
  logic [3:0]  be0;
`endif

  int checks = 0;
  int errors = 0;

  dmem_delay_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
`ifdef DMEM_BYTE_EN
    .be(be2),
`endif
    .busy(busy2), .ready(ready2), .rdata(rdata2), .err(err2)
  );

  dmem_delay_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DMEM_BYTE_EN
    .be(be0),
`endif
    .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic issue2(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    @(posedge clk); #1;
    req2 = 1'b0;
  endtask

  task automatic issue0(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  // Cycles from acceptance until ready2 is seen; -1 if it never comes.
  task automatic wait_ready2(output int cyc);
    logic done;
    cyc  = -1;
    done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!done) begin
        @(posedge clk); #1;
        if (ready2) begin
          cyc  = i;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy2, ready2, err2} !== 3'b000 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_l2: busy/ready/err=%b rdata=%h want 000 00000000",
               {busy2, ready2, err2}, rdata2);
    end
    checks++;
    if ({busy0, ready0, err0} !== 3'b000 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_l0: busy/ready/err=%b rdata=%h want 000 00000000",
               {busy0, ready0, err0}, rdata0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load_l2();
    logic [4:0] exp_busy  = 5'b01110;
    logic [4:0] exp_ready = 5'b01000;
    int cyc;
    issue2(1'b1, 32'h10, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (busy2 !== exp_busy[c] || ready2 !== exp_ready[c] || err2 !== 1'b0) begin
        errors++;
        $display("FAIL store_timing c%0d: busy=%b ready=%b err=%b want %b %b 0",
                 c, busy2, ready2, err2, exp_busy[c], exp_ready[c]);
      end
    end
    issue2(1'b0, 32'h10, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL load_latency: got %0d want 3", cyc);
    end
    checks++;
    if (rdata2 !== 32'hDEADBEEF || err2 !== 1'b0) begin
      errors++;
      $display("FAIL load_data: rdata=%h err=%b want deadbeef 0", rdata2, err2);
    end
  endtask

  task automatic test_latency0();
    issue0(1'b1, 32'h0, 32'h11111111);
    checks++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL l0_accept: ready=%b busy=%b want 0 0", ready0, busy0);
    end
    @(posedge clk); #1;
    checks++;
    if (ready0 !== 1'b1 || busy0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL l0_store_ready: ready=%b busy=%b err=%b want 1 1 0", ready0, busy0, err0);
    end
    issue0(1'b0, 32'h0, 32'h0);
    checks++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL l0_b2b_accept: ready=%b busy=%b want 0 0", ready0, busy0);
    end
    @(posedge clk); #1;
    checks++;
    if (ready0 !== 1'b1 || rdata0 !== 32'h11111111 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL l0_load: ready=%b rdata=%h err=%b want 1 11111111 0", ready0, rdata0, err0);
    end
  endtask

  task automatic test_misaligned();
    int cyc;
    issue2(1'b1, 32'h20, 32'h0BADCAFE);
    wait_ready2(cyc);
    issue2(1'b0, 32'h10, 32'h0);
    wait_ready2(cyc);
    issue2(1'b0, 32'h23, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (cyc !== 3 || err2 !== 1'b1 || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misaligned_load: cyc=%0d err=%b rdata=%h want 3 1 deadbeef", cyc, err2, rdata2);
    end
    issue2(1'b1, 32'h12, 32'h12345678);
    wait_ready2(cyc);
    checks++;
    if (cyc !== 3 || err2 !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store: cyc=%0d err=%b want 3 1", cyc, err2);
    end
    issue2(1'b0, 32'h10, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (err2 !== 1'b0 || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misaligned_nowrite: err=%b rdata=%h want 0 deadbeef", err2, rdata2);
    end
    issue2(1'b0, 32'h20, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (err2 !== 1'b0 || rdata2 !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL aligned_after_err: err=%b rdata=%h want 0 0badcafe", err2, rdata2);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    issue2(1'b1, 32'h404, 32'hCAFEF00D);
    wait_ready2(cyc);
    issue2(1'b0, 32'h004, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (rdata2 !== 32'hCAFEF00D || err2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap: rdata=%h err=%b want cafef00d 0", rdata2, err2);
    end
  endtask

  task automatic test_drop();
    int pulses = 0;
    int cyc;
    issue2(1'b1, 32'h30, 32'hAAAA0001);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h10; wdata2 = 32'h55;
    @(posedge clk); #1;
    req2 = 1'b0;
    if (ready2) pulses++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready2) pulses++;
    end
    checks++;
    if (pulses !== 1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulses: pulses=%0d busy=%b want 1 0", pulses, busy2);
    end
    issue2(1'b0, 32'h30, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (rdata2 !== 32'hAAAA0001) begin
      errors++;
      $display("FAIL drop_inflight_data: rdata=%h want aaaa0001", rdata2);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    int cyc;
    issue2(1'b1, 32'h40, 32'h00000077);
    wait_ready2(cyc);
    issue2(1'b1, 32'h40, 32'h00000005);
    @(posedge clk); #1;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: busy=%b want 1", busy2);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || ready2 !== 1'b0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL abort_async: busy=%b ready=%b rdata=%h want 0 0 00000000", busy2, ready2, rdata2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready2) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_ready: pulses=%0d want 0", pulses);
    end
    issue2(1'b0, 32'h40, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (cyc !== 3 || rdata2 !== 32'h00000077) begin
      errors++;
      $display("FAIL abort_no_write: cyc=%0d rdata=%h want 3 00000077", cyc, rdata2);
    end
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_byte_en();
    int cyc;
    be2 = 4'b1111;
    issue2(1'b1, 32'h50, 32'hFFFFFFFF);
    wait_ready2(cyc);
    be2 = 4'b0101;
    issue2(1'b1, 32'h50, 32'h00000000);
    wait_ready2(cyc);
    be2 = 4'b0000;
    issue2(1'b0, 32'h50, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (rdata2 !== 32'hFF00FF00) begin
      errors++;
      $display("FAIL byte_en_merge: rdata=%h want ff00ff00", rdata2);
    end
    issue2(1'b1, 32'h50, 32'h12345678);
    wait_ready2(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL byte_en_zero_ready: cyc=%0d want 3", cyc);
    end
    be2 = 4'b1111;
    issue2(1'b0, 32'h50, 32'h0);
    wait_ready2(cyc);
    checks++;
    if (rdata2 !== 32'hFF00FF00) begin
      errors++;
      $display("FAIL byte_en_zero_nowrite: rdata=%h want ff00ff00", rdata2);
    end
  endtask
`endif

  initial begin
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
`ifdef DMEM_BYTE_EN
    be2 = 4'hF;
    be0 = 4'hF;
`endif
    test_reset();
    test_store_load_l2();
    test_latency0();
    test_misaligned();
    test_wrap();
    test_drop();
    test_abort();
`ifdef DMEM_BYTE_EN
    test_byte_en();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_delay_responder.md
Name: dmem_delay_responder

Overview:
- Responder end of the processor's data-memory port: a word-addressed data memory that answers load/store requests after a programmable number of wait cycles.
- Used under the stall-based pipelined core in place of a zero-latency memory. It exercises the core's load-stall logic with a real req/ready handshake.
- Single outstanding transaction; no queueing.

Parameters:
- ADDR_WIDTH, 8, log2 of memory depth in 32-bit words (256 words by default).
- LATENCY, 2, wait cycles between request acceptance and the ready pulse; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the port is named reset.
- req  input  1  request strobe, sampled only in IDLE.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2].
- wdata  input  32  store data; sampled with req.
- busy  output  1  high from the cycle after acceptance until the ready cycle, inclusive.
- ready  output  1  one-cycle completion pulse.
- rdata  output  32  load data; valid in the ready cycle, held until the next load completes.
- err  output  1  misaligned-access flag; asserted together with ready.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, ready=0, err=0, rdata=0, wait counter=0. Memory array contents are not reset.
- FSM states:
  - IDLE: on req=1, latch we, addr, wdata, and load cnt=LATENCY. Go to WAIT if LATENCY>0, otherwise go to RESP.
  - WAIT: cnt decrements every cycle. When cnt reaches 1, go to RESP next cycle.
  - RESP: perform the access and assert ready for exactly one cycle, then return to IDLE.
- Total latency: ready is high LATENCY+1 cycles after the req-sampling edge. With LATENCY=0, ready rises on the edge after acceptance.
- Store in RESP: mem[index] <= latched wdata. rdata is unchanged.
- Load in RESP: rdata <= mem[index].
- Misaligned access (latched addr[1:0] != 0): ready=1 and err=1. No memory write; rdata is unchanged.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2) bytes.
- req while busy, or in the RESP cycle, is ignored: it is not queued and not latched. The requester must hold req or re-assert it in IDLE.
- req in the cycle right after RESP (state=IDLE) is accepted normally, giving back-to-back throughput of one transaction per LATENCY+2 cycles.
- Changes on we/addr/wdata after acceptance have no effect on the transaction in flight.
- Reset asserted mid-transaction aborts it: no write occurs, ready is not pulsed, and state returns to IDLE.
- ready and err are registered outputs with no combinational path from inputs. busy is registered.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- When defined: an extra input port be (4 bits) is sampled with req. A store writes only the bytes whose be bit is 1 (be[0]=bits 7:0 ... be[3]=bits 31:24). be=0000 completes with ready and writes nothing. Loads ignore be.
- When undefined: port be does not exist and every store writes the full word.

Test Plan:
- LATENCY=2: store addr=0x10, wdata=0xDEADBEEF at cycle 0 -> ready high at cycle 3 with busy=1 in cycles 1-3. Then load addr=0x10 -> rdata=0xDEADBEEF at its ready cycle, err=0.
- LATENCY=0: store 0x11111111 to 0x0, then load 0x0 back-to-back -> each ready arrives one cycle after acceptance, rdata=0x11111111.
- Load addr=0x13 (misaligned) -> ready=1, err=1, rdata keeps its previous value. A prior store to 0x12/0x10 region is unchanged.
- Wrap, ADDR_WIDTH=8: store 0xCAFEF00D to addr=0x404 -> load 0x004 returns 0xCAFEF00D.
- Drop and abort: a second req pulsed during WAIT -> exactly one ready pulse. Separately, store 0x5 issued and reset pulsed low in WAIT -> no ready, and a later load of that address returns the pre-store value.
- DMEM_BYTE_EN defined: store 0xFFFFFFFF be=1111, then store 0x00000000 be=0101 -> load returns 0xFF00FF00.
